// File: rtl/freq_pkg.sv
// Shared constants and state encoding for the tone generator and estimator.
package freq_pkg;
  localparam int WINDOW_CYCLES = 1600;
  localparam int CNT_W = 10;
  localparam int TIME_W = 11;
  localparam int AMP = 7;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;
endpackage

// File: rtl/freq_gen_if.sv
// Config port for the tone generator: N offered with valid/ready.
interface freq_gen_if;
  import freq_pkg::*;

  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/freq_gen_dda.sv
// DDA accumulator: adds N per cycle, wraps at WINDOW and toggles the sign.
module freq_gen_dda #(
  parameter int WINDOW = 1600,
  parameter int CNT_W  = 10,
  parameter int TIME_W = 11
) (
  input  logic             clk,
  input  logic             RESETn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] n_i,
  output logic             sign_o
);
  localparam logic [TIME_W:0] W_EXT = (TIME_W+1)'(WINDOW);

  logic [TIME_W-1:0] acc_q, acc_d;
  logic              sign_q, sign_d;
  logic [TIME_W:0]   s;
  logic              wrap;

  always_comb begin
    s      = {1'b0, acc_q} + (TIME_W+1)'(n_i);
    wrap   = (s >= W_EXT);
    acc_d  = acc_q;
    sign_d = sign_q;
    if (clr_i) begin
      acc_d  = '0;
      sign_d = 1'b0;
    end else if (en_i) begin
      acc_d  = TIME_W'(wrap ? s - W_EXT : s);
      sign_d = sign_q ^ wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      acc_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sign_q <= sign_d;
    end
  end

  assign sign_o = sign_q;
endmodule

// File: rtl/freq_gen.sv
// Square-wave test tone with N sign toggles per WINDOW clocks.
// FREQ_GEN_NOISE_EN adds LFSR amplitude jitter of -1/0/+1, clamped to 1..7.
module freq_gen #(
  parameter int WINDOW = freq_pkg::WINDOW_CYCLES,
  parameter int CNT_W  = freq_pkg::CNT_W,
  parameter int TIME_W = freq_pkg::TIME_W,
  parameter int AMP    = freq_pkg::AMP
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic              stop,
  freq_gen_if.slave         cfg,
  output logic signed [3:0] signal,
  output logic              window_start,
  output logic              active
);
  import freq_pkg::*;

  localparam logic [TIME_W-1:0] T_LAST = TIME_W'(WINDOW - 1);
  localparam logic [3:0]        AMP4   = 4'(AMP);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [CNT_W-1:0]  n_q, n_d, pn_q, pn_d;
  logic              loaded_q, loaded_d;
  logic              pend_q, pend_d;
  logic [3:0]        sig_q, sig_d;
  logic              ws_q, ws_d;
  logic              act_q, act_d;
  logic              dda_clr, dda_en, sign;
  logic              xfer, wrap;
  logic [3:0]        mag;

  assign xfer = cfg.cfg_valid & ~pend_q;

`ifdef FREQ_GEN_NOISE_EN
  logic [6:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == RUN && !stop)
      lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  always_ff @(posedge clk) begin
    if (!RESETn) lfsr_q <= 7'h01;
    else         lfsr_q <= lfsr_d;
  end

  // Clamp keeps magnitude nonzero so the sign bit is never disturbed
  always_comb begin
    mag = AMP4;
    if (lfsr_q[1:0] == 2'b00 && AMP4 > 4'd1)
      mag = AMP4 - 4'd1;
    else if (lfsr_q[1] && AMP4 < 4'd7)
      mag = AMP4 + 4'd1;
  end
`else
  assign mag = AMP4;
`endif

  freq_gen_dda #(
    .WINDOW(WINDOW),
    .CNT_W (CNT_W),
    .TIME_W(TIME_W)
  ) u_dda (
    .clk   (clk),
    .RESETn(RESETn),
    .clr_i (dda_clr),
    .en_i  (dda_en),
    .n_i   (n_q),
    .sign_o(sign)
  );

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    n_d      = n_q;
    pn_d     = pn_q;
    loaded_d = loaded_q;
    pend_d   = pend_q;
    sig_d    = sig_q;
    ws_d     = 1'b0;
    act_d    = act_q;
    dda_clr  = 1'b0;
    dda_en   = 1'b0;
    wrap     = (time_q == T_LAST);
    if (stop) begin
      state_d = IDLE;
      time_d  = '0;
      pend_d  = 1'b0;
      sig_d   = '0;
      act_d   = 1'b0;
      dda_clr = 1'b1;
      if (xfer) begin
        n_d      = cfg.cfg_count;
        loaded_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          sig_d = '0;
          act_d = 1'b0;
          if (xfer) begin
            n_d      = cfg.cfg_count;
            loaded_d = 1'b1;
          end
          if (xfer || loaded_q) begin
            state_d = RUN;
            time_d  = '0;
            dda_clr = 1'b1;
            ws_d    = 1'b1;
            act_d   = 1'b1;
          end
        end
        RUN: begin
          dda_en = 1'b1;
          act_d  = 1'b1;
          ws_d   = wrap;
          time_d = wrap ? '0 : time_q + 1'b1;
          sig_d  = sign ? 4'd0 - mag : mag;
          // New N takes effect only on a window boundary
          if (wrap && pend_q) begin
            n_d    = pn_q;
            pend_d = 1'b0;
          end
          if (xfer) begin
            pend_d = 1'b1;
            pn_d   = cfg.cfg_count;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      time_q   <= '0;
      n_q      <= '0;
      pn_q     <= '0;
      loaded_q <= 1'b0;
      pend_q   <= 1'b0;
      sig_q    <= '0;
      ws_q     <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      n_q      <= n_d;
      pn_q     <= pn_d;
      loaded_q <= loaded_d;
      pend_q   <= pend_d;
      sig_q    <= sig_d;
      ws_q     <= ws_d;
      act_q    <= act_d;
    end
  end

  assign cfg.cfg_ready = ~pend_q;
  assign signal        = $signed(sig_q);
  assign window_start  = ws_q;
  assign active        = act_q;
endmodule

// File: tb/tb_freq_gen.sv
// Scoreboard bench for freq_gen: expected per-window toggle counts are queued
// by the stimulus and checked by a monitor that closes each observed window.
module tb_freq_gen;
  import freq_pkg::*;

  localparam int W = WINDOW_CYCLES;

  logic              clk = 1'b0;
  logic              RESETn = 1'b0;
  logic              stop = 1'b0;
  logic signed [3:0] signal;
  logic              window_start;
  logic              active;

  freq_gen_if cfg_if();

  freq_gen dut (
    .clk         (clk),
    .RESETn      (RESETn),
    .stop        (stop),
    .cfg         (cfg_if),
    .signal      (signal),
    .window_start(window_start),
    .active      (active)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic chk(input string name,
                     input logic signed [31:0] got,
                     input logic signed [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Monitor: signal lags the window timer by two cycles, so each window's
  // toggles are closed out two samples after its window_start.
  bit         open = 0;
  int         cnt = 0;
  logic [1:0] wsh = '0;
  bit         prev_act = 0;
  logic       prev_s = 1'b0;
  int         since = 0;
  bit         have_last = 0;
  bit         amp_ok;

  always @(negedge clk) begin
    if (active !== 1'b1) begin
      open      = 0;
      wsh       = '0;
      have_last = 0;
      prev_act  = 0;
    end else begin
      if (wsh[1]) begin
        if (open) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL win_unexpected: got %0d toggles, required no window", cnt);
          end else begin
            chk("win_toggles", cnt, exp_q.pop_front());
          end
        end
        open = 1;
        cnt  = 0;
      end
      if (prev_act) begin
        if (signal[3] !== prev_s) cnt++;
`ifdef FREQ_GEN_NOISE_EN
        amp_ok = (signal != 0) && (signal !== 4'b1000);
`else
        amp_ok = (signal === 4'sd7) || (signal === -4'sd7);
`endif
        chk("amplitude", amp_ok, 1);
      end
      since++;
      if (window_start === 1'b1) begin
        if (have_last) chk("ws_period", since, W);
        have_last = 1;
        since     = 0;
      end
      wsh      = {wsh[0], window_start};
      prev_act = 1;
      prev_s   = signal[3];
    end
  end

  task automatic send(input int n);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_count = CNT_W'(n);
    chk("cfg_ready_offer", cfg_if.cfg_ready, 1);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_ws(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (window_start !== 1'b1 && k < 2 * W);
    if (window_start !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no window_start, required one within %0d", name, 2 * W);
    end
  endtask

  task automatic restart(input int n, input bit do_cfg,
                         input int exp_n, input int nwin);
    stop = 1'b1;
    @(negedge clk);
    chk("stop_signal", signal, 0);
    chk("stop_active", active, 0);
    if (do_cfg) send(n);
    repeat (nwin) exp_q.push_back(exp_n);
    stop = 1'b0;
    @(negedge clk);
    chk("release_ws", window_start, 1);
    repeat (nwin * W + 10) @(negedge clk);
  endtask

  initial begin
    int hi;
    int k;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_signal", signal, 0);
    chk("rst_ws", window_start, 0);
    chk("rst_active", active, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    RESETn = 1'b1;
    @(negedge clk);
    chk("idle_no_n", active, 0);

    // N=100 loaded in IDLE, three full windows
    repeat (3) exp_q.push_back(100);
    send(100);
    chk("t1_ws", window_start, 1);
    chk("t1_active", active, 1);
    repeat (3 * W + 10) @(negedge clk);

    // Reconfigure to 500 mid-window
    exp_q.push_back(100);
    exp_q.push_back(100);
    exp_q.push_back(500);
    wait_ws("t4_ws");
    repeat (800) @(negedge clk);
    send(500);
    chk("t4_ready_low", cfg_if.cfg_ready, 0);
    hi = 0;
    k = 0;
    while (window_start !== 1'b1 && k < 2 * W) begin
      if (cfg_if.cfg_ready !== 1'b0) hi = 1;
      @(negedge clk);
      k++;
    end
    chk("t4_ready_held", hi, 0);
    chk("t4_boundary_ws", window_start, 1);
    chk("t4_ready_boundary", cfg_if.cfg_ready, 1);
    wait_ws("t4_next");
    repeat (5) @(negedge clk);

    // Stop mid-window; N=500 survives the stop
    repeat (700) @(negedge clk);
    restart(0, 1'b0, 500, 2);

    // N=0: constant +AMP
    restart(0, 1'b1, 0, 2);
    chk("t2_level", signal, 7);

    // N at maximum
    restart(1023, 1'b1, 1023, 2);

    // Reset mid-run clears everything including the loaded N
    RESETn = 1'b0;
    @(negedge clk);
    chk("mid_rst_signal", signal, 0);
    chk("mid_rst_ws", window_start, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_ready", cfg_if.cfg_ready, 1);
    RESETn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", active, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
